// File: rtl/prog_seq_pkg.sv
// prog_seq_pkg: shared width defaults and loop-stack entry type for the nested-loop program sequencer
// Entry fields are sized by P_AW/P_CW; instances overriding AW/CW must keep them equal to these.
package prog_seq_pkg;
   localparam int P_AW    = 16;
   localparam int P_CW    = 12;
   localparam int P_DEPTH = 4;
   typedef struct packed {
      logic [P_AW-1:0] start_addr;
      logic [P_AW-1:0] end_addr;
      logic [P_CW-1:0] count;
      logic            valid;
   } loop_entry_t;
endpackage

// File: rtl/prog_seq_stack.sv
// prog_seq_stack: LIFO of loop entries with push, pop of one or two, and decrement of the surviving top
// Ports: clk/reset (async active-low); push_i/push_data_i write a new top unless full;
// pop_n_i removes 0..2 entries; dec_i decrements the count of the top left after the pops;
// top_o/below_o read the two uppermost entries (zero when absent); full_o, empty_o, count_o.
module prog_seq_stack
   import prog_seq_pkg::*;
#(
   parameter int  DEPTH = P_DEPTH,
   localparam int DW    = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push_i,
   input  loop_entry_t   push_data_i,
   input  logic [1:0]    pop_n_i,
   input  logic          dec_i,
   output loop_entry_t   top_o,
   output loop_entry_t   below_o,
   output logic          full_o,
   output logic          empty_o,
   output logic [DW-1:0] count_o
);
   localparam int IW = $clog2(DEPTH);
   loop_entry_t   mem_q [DEPTH];
   logic [DW-1:0] cnt_q;
   logic [IW-1:0] top_idx, blw_idx, dec_idx;
   logic          push_ok;
   assign top_idx = IW'(cnt_q - DW'(1));
   assign blw_idx = IW'(cnt_q - DW'(2));
   assign dec_idx = (pop_n_i != 2'd0) ? blw_idx : top_idx;
   assign full_o  = cnt_q == DW'(DEPTH);
   assign empty_o = cnt_q == '0;
   assign push_ok = push_i && !full_o;
   assign top_o   = empty_o ? '0 : mem_q[top_idx];
   assign below_o = (cnt_q >= DW'(2)) ? mem_q[blw_idx] : '0;
   assign count_o = cnt_q;
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         cnt_q <= cnt_q - DW'(pop_n_i) + DW'(push_ok);
         if (push_ok) mem_q[IW'(cnt_q)] <= push_data_i;
         if (dec_i) mem_q[dec_idx].count <= mem_q[dec_idx].count - P_CW'(1);
         if (pop_n_i != 2'd0) mem_q[top_idx].valid <= 1'b0;
         if (pop_n_i == 2'd2) mem_q[blw_idx].valid <= 1'b0;
      end
   end
endmodule

// File: rtl/prog_seq_nest.sv
// prog_seq_nest: program address sequencer with hardware nested loops and optional branch
// Ports: clk, reset (async active-low); we/iter/size request a loop whose body is the next
// size+1 instructions run iter times; stall freezes everything; jump_en/jump_addr branch
// (only when PROG_SEQ_BRANCH_EN is defined, otherwise ignored); addr, depth, sticky err.
module prog_seq_nest
   import prog_seq_pkg::*;
#(
   parameter int AW    = P_AW,
   parameter int CW    = P_CW,
   parameter int DEPTH = P_DEPTH
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   we,
   input  logic [CW-1:0]          iter,
   input  logic [CW-1:0]          size,
   input  logic                   stall,
   input  logic                   jump_en,
   input  logic [AW-1:0]          jump_addr,
   output logic [AW-1:0]          addr,
   output logic [$clog2(DEPTH):0] depth,
   output logic                   err
);
   loop_entry_t   top, blw, new_ent;
   logic          full, empty, at_end, casc, dec, push, jmp;
   logic [1:0]    pop_n;
   logic [AW-1:0] addr_q, addr_d, addr_inc, jmp_tgt;
   logic          err_q, err_d;
`ifdef PROG_SEQ_BRANCH_EN
   assign jmp     = jump_en;
   assign jmp_tgt = jump_addr;
`else
   logic unused_jump;
   assign unused_jump = ^{jump_en, jump_addr};
   assign jmp         = 1'b0;
   assign jmp_tgt     = '0;
`endif
   assign addr_inc = addr_q + AW'(1);
   assign new_ent  = '{start_addr: addr_inc, end_addr: addr_inc + AW'(size), count: iter, valid: 1'b1};
   assign at_end   = !empty && top.valid && (addr_q == top.end_addr);
   // a popped loop may share its last instruction with the enclosing one
   assign casc     = blw.valid && (blw.end_addr == addr_q);
   always_comb begin
      addr_d = addr_inc;
      err_d  = err_q;
      pop_n  = 2'd0;
      dec    = 1'b0;
      push   = 1'b0;
      if (stall) begin
         addr_d = addr_q;
      end else if (jmp) begin
         addr_d = jmp_tgt;
         err_d  = err_q | we;
      end else if (at_end) begin
         err_d = err_q | we;
         if (top.count > CW'(1)) begin
            addr_d = top.start_addr;
            dec    = 1'b1;
         end else if (casc && blw.count > CW'(1)) begin
            addr_d = blw.start_addr;
            pop_n  = 2'd1;
            dec    = 1'b1;
         end else begin
            pop_n = casc ? 2'd2 : 2'd1;
         end
      end else if (we) begin
         err_d = err_q | full;
         push  = !full && iter > CW'(1);
      end
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         addr_q <= '0;
         err_q  <= 1'b0;
      end else begin
         addr_q <= addr_d;
         err_q  <= err_d;
      end
   end
   prog_seq_stack #(.DEPTH(DEPTH)) u_stack (
      .clk         (clk),
      .reset       (reset),
      .push_i      (push),
      .push_data_i (new_ent),
      .pop_n_i     (pop_n),
      .dec_i       (dec),
      .top_o       (top),
      .below_o     (blw),
      .full_o      (full),
      .empty_o     (empty),
      .count_o     (depth)
   );
   assign addr = addr_q;
   assign err  = err_q;
endmodule

// File: doc/prog_seq_nest.md
PROG_SEQ_NEST -- requirements
Module: prog_seq_nest

Interface
REQ-001 The block SHALL have parameter AW, default 16, program address width.
REQ-002 The block SHALL have parameter CW, default 12, width of the iter and size inputs.
REQ-003 The block SHALL have parameter DEPTH, default 4, number of loop stack entries (2..16).
REQ-004 The block SHALL use one clock; reset SHALL be asynchronous and active-low.
REQ-005 The block SHALL have these ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- we  in  1  loop init request for this cycle.
- iter  in  CW  total passes of the loop body.
- size  in  CW  offset from first to last body instruction.
- stall  in  1  hold the address and all state.
- jump_en  in  1  branch request.
- jump_addr  in  AW  branch target.
- addr  out  AW  current program address (registered).
- depth  out  log2(DEPTH)+1  number of active loops.
- err  out  1  sticky error flag.

Function
REQ-006 Per cycle, precedence SHALL be: stall > jump > loop-end > sequential increment.
REQ-007 With no other action, addr SHALL become addr+1 and SHALL wrap modulo 2^AW.
REQ-008 On we with iter>=2 and the stack not full, the block SHALL push entry {start=addr+1, end=addr+1+size, count=iter}; addr SHALL still increment.
REQ-009 On we with iter<=1, no entry SHALL be pushed; the body executes once by fall-through.
REQ-010 Loop-end condition: stack non-empty and addr == top.end.
- count>1: next addr SHALL be top.start and count SHALL be decremented.
- count==1: the top SHALL be popped.
REQ-011 On a pop, if the new top also has end == addr, that entry SHALL be evaluated per REQ-010 in the same cycle (one cascade level); otherwise next addr SHALL be addr+1.
REQ-012 we on a full stack SHALL NOT push and SHALL set err; addr SHALL increment normally.
REQ-013 When we and loop-end occur in the same cycle, loop-end SHALL apply, the push SHALL be dropped, and err SHALL be set.
REQ-014 jump_en SHALL load addr=jump_addr and leave the stack unchanged; a pending we in the same cycle SHALL be dropped and SHALL set err.
REQ-015 stall SHALL freeze addr, the stack, depth and err; we and jump_en SHALL be ignored while stall=1.
REQ-016 depth SHALL equal the number of valid stack entries, updated in the same cycle as the push or pop.
REQ-017 Start and end address arithmetic SHALL be AW bits and wrap; size SHALL be zero-extended to AW.
REQ-018 err SHALL be cleared only by reset.

Reset
REQ-019 Asserting reset (low) SHALL immediately force addr=0, depth=0, err=0 and invalidate all stack entries, including mid-loop.
REQ-020 After reset deasserts, the first rising edge SHALL produce addr=1, given no we, jump or stall.

Configuration
REQ-021 When PROG_SEQ_BRANCH_EN is defined, jump_en/jump_addr SHALL behave per REQ-014.
REQ-022 When PROG_SEQ_BRANCH_EN is undefined, the jump ports SHALL exist but be ignored, no branch logic SHALL be synthesised, and the REQ-014 err condition SHALL never occur.

Structure
REQ-023 Package prog_seq_pkg SHALL hold the AW/CW/DEPTH defaults and the loop-entry struct typedef (start, end, count, valid).
REQ-024 Sub-module prog_seq_stack SHALL implement the LIFO: push, pop, top and next-below read, full, empty, and count.

Verification
REQ-025 Reset then release: addr=0 during reset, then 1, 2, 3 on successive edges.
REQ-026 At addr=1, we=1, iter=2, size=4: addr visits 2..6, jumps to 2, visits 2..6 again, then reaches 7; depth goes 1 then 0 after the pop.
REQ-027 Nested case: outer iter=2, size=6 issued at addr=1; inner iter=3, size=1 issued at addr=3. Inner body 4,5 runs 3 times per outer pass; total addresses visited before addr=9 match the model.
REQ-028 Shared end: outer and inner loops both end at 6; the cascade pop exits both in one cycle and depth drops 2 to 0.
REQ-029 Push DEPTH+1 loops: the last push is ignored, err=1, depth=DEPTH; stall=1 for 3 cycles mid-loop holds addr.
REQ-030 With PROG_SEQ_BRANCH_EN: jump_en at addr=5 with jump_addr=0x40 gives addr=0x40 next and the stack unchanged. Without the macro: addr=6 next.
